// File: rtl/slice_add_seq_pkg.sv
// Shared types and sizing helpers for the slice-sequenced adder.
package slice_add_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Slice index width: ceil(log2(n)), never below one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_add_seq_add4_slice.sv
// Gate primitives and the combinational SLICE-bit carry-lookahead slice
// (4-bit lookahead groups, group carries rippled; SLICE a multiple of 4).
module xor2 (input logic i_a, input logic i_b, output logic o_y);
  assign o_y = i_a ^ i_b;
endmodule

module and2 (input logic i_a, input logic i_b, output logic o_y);
  assign o_y = i_a & i_b;
endmodule

module and3 (input logic i_a, input logic i_b, input logic i_c, output logic o_y);
  assign o_y = i_a & i_b & i_c;
endmodule

module and4 (input logic i_a, input logic i_b, input logic i_c, input logic i_d,
             output logic o_y);
  assign o_y = i_a & i_b & i_c & i_d;
endmodule

module or2 (input logic i_a, input logic i_b, output logic o_y);
  assign o_y = i_a | i_b;
endmodule

module or3 (input logic i_a, input logic i_b, input logic i_c, output logic o_y);
  assign o_y = i_a | i_b | i_c;
endmodule

module or4 (input logic i_a, input logic i_b, input logic i_c, input logic i_d,
            output logic o_y);
  assign o_y = i_a | i_b | i_c | i_d;
endmodule

module add4_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_c,
  output logic [SLICE-1:0] o_s,
  output logic             o_c,
  output logic             o_c_msb_in
);
  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE:0]   w_c;

  assign w_c[0] = i_c;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    xor2 u_p (.i_a(i_a[i]), .i_b(i_b[i]), .o_y(w_p[i]));
    and2 u_g (.i_a(i_a[i]), .i_b(i_b[i]), .o_y(w_g[i]));
    xor2 u_s (.i_a(w_p[i]), .i_b(w_c[i]), .o_y(o_s[i]));
  end

  for (genvar k = 0; k < SLICE / 4; k++) begin : g_grp
    localparam int B = 4 * k;
    logic w_t10, w_t20, w_t21, w_t30, w_t31, w_t32;
    logic w_u0, w_u1, w_u2, w_u3, w_gg, w_gp;

    and2 u_t10 (.i_a(w_p[B]), .i_b(w_c[B]), .o_y(w_t10));
    or2  u_c1  (.i_a(w_g[B]), .i_b(w_t10), .o_y(w_c[B+1]));

    and2 u_t20 (.i_a(w_p[B+1]), .i_b(w_g[B]), .o_y(w_t20));
    and3 u_t21 (.i_a(w_p[B+1]), .i_b(w_p[B]), .i_c(w_c[B]), .o_y(w_t21));
    or3  u_c2  (.i_a(w_g[B+1]), .i_b(w_t20), .i_c(w_t21), .o_y(w_c[B+2]));

    and2 u_t30 (.i_a(w_p[B+2]), .i_b(w_g[B+1]), .o_y(w_t30));
    and3 u_t31 (.i_a(w_p[B+2]), .i_b(w_p[B+1]), .i_c(w_g[B]), .o_y(w_t31));
    and4 u_t32 (.i_a(w_p[B+2]), .i_b(w_p[B+1]), .i_c(w_p[B]), .i_d(w_c[B]), .o_y(w_t32));
    or4  u_c3  (.i_a(w_g[B+2]), .i_b(w_t30), .i_c(w_t31), .i_d(w_t32), .o_y(w_c[B+3]));

    // Group carry-out as generate/propagate so no gate exceeds four inputs.
    and2 u_u0 (.i_a(w_p[B+3]), .i_b(w_g[B+2]), .o_y(w_u0));
    and3 u_u1 (.i_a(w_p[B+3]), .i_b(w_p[B+2]), .i_c(w_g[B+1]), .o_y(w_u1));
    and4 u_u2 (.i_a(w_p[B+3]), .i_b(w_p[B+2]), .i_c(w_p[B+1]), .i_d(w_g[B]), .o_y(w_u2));
    or4  u_gg (.i_a(w_g[B+3]), .i_b(w_u0), .i_c(w_u1), .i_d(w_u2), .o_y(w_gg));
    and4 u_gp (.i_a(w_p[B+3]), .i_b(w_p[B+2]), .i_c(w_p[B+1]), .i_d(w_p[B]), .o_y(w_gp));
    and2 u_u3 (.i_a(w_gp), .i_b(w_c[B]), .o_y(w_u3));
    or2  u_c4 (.i_a(w_gg), .i_b(w_u3), .o_y(w_c[B+4]));
  end

  assign o_c        = w_c[SLICE];
  assign o_c_msb_in = w_c[SLICE-1];

endmodule

// File: rtl/slice_add_seq.sv
// Multi-cycle WIDTH-bit adder: one SLICE-bit slice per clock with a registered
// carry. Define SLICE_ADD_SEQ_OVF_EN to add the signed-overflow output.
module slice_add_seq
  import slice_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
`ifdef SLICE_ADD_SEQ_OVF_EN
  output logic             ovf,
`endif
  output state_t           o_state
);
  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = idx_bits(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Valid/ready: a transfer happens on a rising edge where valid and ready
  // are both high; in_ready and out_valid depend only on state, and the
  // result stays stable while out_valid is high and out_ready is low.
  state_t           r_state, w_next;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_cout;
  logic [SLICE-1:0] w_sa, w_sb, w_s;
  logic             w_c, w_c_msb, w_last;

  assign w_sa   = r_a[int'(r_idx)*SLICE +: SLICE];
  assign w_sb   = r_b[int'(r_idx)*SLICE +: SLICE];
  assign w_last = (r_idx == LAST_IDX);

  add4_slice #(.SLICE(SLICE)) u_slice (
    .i_a        (w_sa),
    .i_b        (w_sb),
    .i_c        (r_carry),
    .o_s        (w_s),
    .o_c        (w_c),
    .o_c_msb_in (w_c_msb)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)         w_next = ST_RUN;
      ST_RUN:  if (w_last)           w_next = ST_DONE;
      ST_DONE: if (out_ready)        w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_sum[int'(r_idx)*SLICE +: SLICE] <= w_s;
      r_carry <= w_c;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) r_cout <= w_c;
    end
  end

`ifdef SLICE_ADD_SEQ_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_ovf <= 1'b0;
    else if (r_state == ST_RUN && w_last) r_ovf <= w_c_msb ^ w_c;
  end
  assign ovf = r_ovf;
`else
  logic w_unused_c_msb;
  assign w_unused_c_msb = w_c_msb;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = !in_ready;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign o_state   = r_state;

endmodule

// File: tb/tb_slice_add_seq.sv
// Self-checking bench for slice_add_seq: directed literal cases plus random
// operations compared every cycle against a cycle-count/queue model.
module tb_slice_add_seq;
  import slice_add_seq_pkg::*;

  localparam int W      = 32;
  localparam int NSL    = W / 4;
  localparam int LAT    = NSL + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  logic         ovf;
  state_t       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  slice_add_seq #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy),
`ifdef SLICE_ADD_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .o_state(dbg_state)
  );
`ifndef SLICE_ADD_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  // Expected entry: {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];
  bit m_idle = 1'b1;
  bit m_done = 1'b0;
  int m_left = 0;

  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {v, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accept starts an NSLICE-cycle run, then result pending until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_done = 1'b0; m_left = 0;
      exp_q.delete();
    end else if (m_done) begin
      if (out_ready) begin
        m_done = 1'b0; m_idle = 1'b1;
        void'(exp_q.pop_front());
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (m_idle && in_valid) begin
      m_idle = 1'b0;
      m_left = NSL;
      exp_q.push_back(ref_add(a, b, cin));
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_idle});
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_done});
      chk("busy", {63'd0, busy}, {63'd0, !m_idle});
      if (m_done) begin
        if (exp_q.size() == 0) chk("queue_nonempty", 64'd0, 64'd1);
        else begin
          chk("sum", {32'd0, sum}, {32'd0, exp_q[0][W-1:0]});
          chk("cout", {63'd0, cout}, {63'd0, exp_q[0][W]});
`ifdef SLICE_ADD_SEQ_OVF_EN
          chk("ovf", {63'd0, ovf}, {63'd0, exp_q[0][W+1]});
`endif
        end
      end
    end
  end

  // driver tasks
  task automatic wait_accept();
    bit acc = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic wait_valid(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    if (!got) chk("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic dequeue(input int stall);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int stall, output logic [W-1:0] rs, output logic rc,
                        output logic ro, output int lat);
    @(posedge clk);
    #1 in_valid = 1'b1; a = ta; b = tb; cin = tc;
    wait_accept();
    #1 in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    wait_valid(lat);
    rs = sum; rc = cout; ro = ovf;
    dequeue(stall);
  endtask

  logic [W-1:0] rs;
  logic         rc, ro;
  int           lat;

  initial begin
    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);

    // Pin the model itself.
    chk("model_carry", {30'd0, ref_add(32'hFFFFFFFF, 32'h1, 1'b0)}, {30'd0, 2'b01, 32'h0});
    chk("model_cin", {30'd0, ref_add(32'h12345678, 32'h9ABCDEF0, 1'b1)}, {30'd0, 2'b00, 32'hACF13569});

    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, rs, rc, ro, lat);
    chk("wrap_sum", {32'd0, rs}, 64'h0);
    chk("wrap_cout", {63'd0, rc}, 64'd1);
    chk("wrap_latency", 64'(lat), 64'(LAT));

    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 2, rs, rc, ro, lat);
    chk("mix_sum", {32'd0, rs}, 64'hACF13569);
    chk("mix_cout", {63'd0, rc}, 64'd0);
    chk("mix_latency", 64'(lat), 64'(LAT));

    // Backpressure with a new operation already offered.
    @(posedge clk);
    #1 in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222; cin = 1'b0;
    wait_accept();
    #1 a = 32'hDEADBEEF; b = 32'h0BADF00D; cin = 1'b1;
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_sum", {32'd0, sum}, 64'h33333333);
      chk("stall_cout", {63'd0, cout}, 64'd0);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_deq_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    chk("held_op_sum", {32'd0, sum}, 64'hEA5BAEFD);
    chk("held_op_cout", {63'd0, cout}, 64'd0);
    chk("held_op_latency", 64'(lat), 64'(LAT));
    dequeue(1);

    // Reset pulse mid-RUN while idx is 3.
    @(posedge clk);
    #1 in_valid = 1'b1; a = 32'hCAFEF00D; b = 32'h87654321; cin = 1'b1;
    wait_accept();
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_sum", {32'd0, sum}, 64'd0);
    chk("mid_rst_cout", {63'd0, cout}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(32'd5, 32'd7, 1'b0, 0, rs, rc, ro, lat);
    chk("after_rst_sum", {32'd0, rs}, 64'd12);
    chk("after_rst_cout", {63'd0, rc}, 64'd0);

`ifdef SLICE_ADD_SEQ_OVF_EN
    run_op(32'h7FFFFFFF, 32'h1, 1'b0, 0, rs, rc, ro, lat);
    chk("ovf_pos_sum", {32'd0, rs}, 64'h80000000);
    chk("ovf_pos_cout", {63'd0, rc}, 64'd0);
    chk("ovf_pos_ovf", {63'd0, ro}, 64'd1);
    run_op(32'h80000000, 32'h80000000, 1'b0, 1, rs, rc, ro, lat);
    chk("ovf_neg_sum", {32'd0, rs}, 64'h0);
    chk("ovf_neg_cout", {63'd0, rc}, 64'd1);
    chk("ovf_neg_ovf", {63'd0, ro}, 64'd1);
    run_op(32'd3, 32'd4, 1'b0, 0, rs, rc, ro, lat);
    chk("ovf_none_sum", {32'd0, rs}, 64'd7);
    chk("ovf_none_ovf", {63'd0, ro}, 64'd0);
`endif

    // Random operations; per-cycle compare checks the results.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (n % 4 == 0) ? ~ra : $urandom;
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), rs, rc, ro, lat);
      chk("rand_latency", 64'(lat), 64'(LAT));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slice_add_seq.md
# slice_add_seq

Multi-cycle adder controller that sequences one narrow combinational adder slice across a wide operand pair, one slice per clock, with a registered carry between slices. It sits between a valid/ready producer and consumer and trades latency for area: one SLICE-bit adder built from the structural gate library serves the full WIDTH-bit add. Input and output both use valid/ready handshakes; one operation is in flight at a time.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SLICE
- SLICE, 4, bits added per cycle by the slice adder
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  operands and cin valid
- in_ready  out  1  block can accept a new operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  sum/cout valid and held stable
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result
- cout  out  1  carry-out of bit WIDTH-1
- busy  out  1  high in RUN and DONE
- ovf  out  1  signed overflow; present only with SLICE_ADD_SEQ_OVF_EN

## Operation
- NSLICE = WIDTH/SLICE; slice index idx is ceil(log2(NSLICE)) bits, 1 minimum.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: latch a, b into operand registers, carry register <= cin, idx <= 0, go to RUN. Inputs are not sampled at any other time.
- RUN: slice adds a[idx*SLICE +: SLICE] + b[same] + carry; result written to sum[idx*SLICE +: SLICE]; carry <= slice carry-out; idx <= idx+1. When idx==NSLICE-1, cout <= slice carry-out and go to DONE.
- DONE: out_valid=1; sum, cout, ovf held constant. On out_valid&&out_ready go to IDLE. No same-cycle accept of a new operation in DONE (in_ready=0).
- Upper slices of sum not yet written in RUN keep previous values; only DONE output is meaningful.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = !in_ready.
- Reset (any state, any cycle, including mid-RUN): state IDLE, idx 0, carry 0, sum 0, cout 0, ovf 0; in-flight operation discarded, no out_valid produced for it.

## Timing
- Accept handshake in cycle 0 -> out_valid high from cycle NSLICE+1 (cycle 9 at defaults); fixed, data-independent.
- Result dequeued in cycle k -> in_ready high in cycle k+1; max throughput one op per NSLICE+2 cycles.
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Critical path: one SLICE-bit slice plus carry mux; no WIDTH-bit combinational path exists.

## Configuration
- SLICE_ADD_SEQ_OVF_EN defined: ovf port exists; in the last RUN cycle ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), taken from the slice's internal MSB carry; held in DONE.
- Undefined: no ovf port, no ovf register; all other behaviour identical.

## Structure
- Package slice_add_seq_pkg: state enum (IDLE, RUN, DONE), default WIDTH/SLICE constants, NSLICE helper function.
- Sub-module add4_slice: combinational SLICE-bit carry-lookahead adder built only from the team gate library (xor2, and2/3/4, or2/3/4); outputs s, c_out and c_msb_in (carry into top bit). Controller holds all registers.

## Test plan
- Reset held low 3 cycles then released -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- a=0xFFFFFFFF, b=0x00000001, cin=0 accepted in cycle 0 -> out_valid first high in cycle 9, sum=0x00000000, cout=1.
- a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0.
- Result pending, out_ready low 5 cycles while in_valid high -> sum/cout stable, in_ready=0, new operands ignored; out_ready high -> in_ready=1 next cycle.
- rst_n pulsed low during RUN at idx=3 -> all outputs reset values immediately, no out_valid; next op a=5, b=7 -> sum=12.
- With SLICE_ADD_SEQ_OVF_EN: a=0x7FFFFFFF, b=1 -> ovf=1, cout=0; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1; a=3, b=4 -> ovf=0.
